pipelined_add_sub: RTL and testbench

- Parametrised successor to the team's 32-bit ripple-carry adder.
- Signed/unsigned add or subtract of WIDTH-bit operands, carry chain broken into STAGE_W-bit chunks, one chunk per pipeline stage.
- Valid/ready streaming with backpressure; one result per cycle when unstalled.
- Sits in the datapath between operand FIFOs and the multiplier/accumulator blocks.

---
 rtl/pipelined_add_sub.sv | 117 +++++++++++
 tb/tb_pipelined_add_sub.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Signed/unsigned add/subtract with the carry chain split into STAGE_W-bit pipeline stages.
// Define ADD_SUB_SAT_EN to clamp overflowing results to the signed limit and add the sat port.
module pipelined_add_sub #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef ADD_SUB_SAT_EN
  ,
  output logic             sat
`endif
);

  localparam int unsigned STAGES = WIDTH / STAGE_W;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned CW     = STAGE_W + 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              ovf_q;

  logic [WIDTH-1:0]  a_x [STAGES];
  logic [WIDTH-1:0]  b_x [STAGES];
  logic [WIDTH-1:0]  s_x [STAGES];
  logic              c_x [STAGES];

  logic [WIDTH-1:0]  s_d [STAGES];
  logic              c_d [STAGES];
  logic              ovf_d;
  logic              advance;

  // Stage 0 works on the ports (with b/cin inverted for subtract); stage k on stage k-1's flops.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_x[k]     = a;
      assign b_x[k]     = sub ? ~b : b;
      assign s_x[k]     = '0;
      assign c_x[k]     = sub ? ~cin : cin;
      assign valid_d[k] = in_valid;
    end else begin : g_body
      assign a_x[k]     = a_q[k-1];
      assign b_x[k]     = b_q[k-1];
      assign s_x[k]     = s_q[k-1];
      assign c_x[k]     = c_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end
  end

  always_comb begin
    logic [STAGE_W:0] chunk;
    chunk = '0;
    for (int k = 0; k < STAGES; k++) begin
      chunk = CW'(a_x[k][k*STAGE_W +: STAGE_W]) + CW'(b_x[k][k*STAGE_W +: STAGE_W])
            + CW'(c_x[k]);
      s_d[k] = s_x[k];
      s_d[k][k*STAGE_W +: STAGE_W] = chunk[STAGE_W-1:0];
      c_d[k] = chunk[STAGE_W];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    ovf_d = a_x[LAST][WIDTH-1] ^ b_x[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
`ifdef ADD_SUB_SAT_EN
    if (ovf_d) begin
      s_d[LAST] = a_x[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Global-enable pipeline: every stage moves together or holds together.
  assign advance  = ~valid_q[LAST] | out_ready;
  assign in_ready = advance & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_x[k];
        b_q[k] <= b_x[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign result    = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;
`ifdef ADD_SUB_SAT_EN
  assign sat       = ovf_q & valid_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed 32/8 checks plus random sweeps of 16/4 and 8/8 instances
// against an arithmetic reference model. Honours ADD_SUB_SAT_EN when defined.
module tb_pipelined_add_sub;
`ifdef ADD_SUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int N_SWEEP = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        in_valid32 = 1'b0, out_ready32 = 1'b1, ci32 = 1'b0, s32 = 1'b0;
  logic        in_ready32, out_valid32, co32, ovf32;
  logic [31:0] a32 = '0, b32 = '0, res32;
  logic        in_valid16 = 1'b0, out_ready16 = 1'b1, ci16 = 1'b0, s16 = 1'b0;
  logic        in_ready16, out_valid16, co16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1, ci8 = 1'b0, s8 = 1'b0;
  logic        in_ready8, out_valid8, co8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0, res8;
`ifdef ADD_SUB_SAT_EN
  logic        sat32, sat16, sat8;
`endif

  logic [33:0] q32 [$];
  logic [33:0] q16 [$];
  logic [33:0] q8  [$];

  pipelined_add_sub #(.WIDTH(32), .STAGE_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .cin(ci32), .sub(s32), .out_valid(out_valid32), .out_ready(out_ready32), .result(res32),
    .cout(co32), .overflow(ovf32)
`ifdef ADD_SUB_SAT_EN
    , .sat(sat32)
`endif
  );

  pipelined_add_sub #(.WIDTH(16), .STAGE_W(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .cin(ci16), .sub(s16), .out_valid(out_valid16), .out_ready(out_ready16), .result(res16),
    .cout(co16), .overflow(ovf16)
`ifdef ADD_SUB_SAT_EN
    , .sat(sat16)
`endif
  );

  pipelined_add_sub #(.WIDTH(8), .STAGE_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(ci8), .sub(s8), .out_valid(out_valid8), .out_ready(out_ready8), .result(res8),
    .cout(co8), .overflow(ovf8)
`ifdef ADD_SUB_SAT_EN
    , .sat(sat8)
`endif
  );

  // Reference: exact integer arithmetic, then truncation, unsigned carry and signed range test.
  function automatic logic [33:0] model(input int w, input longint x, input longint y,
                                        input bit ci, input bit s);
    longint m, h, sx, sy, c, t, r;
    bit co, ov;
    m  = longint'(1) << w;
    h  = m / 2;
    c  = ci ? 1 : 0;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    if (!s) begin
      r  = x + y + c;
      co = (r >= m);
      if (r >= m) r = r - m;
      t  = sx + sy + c;
    end else begin
      r  = x - y - c;
      co = (r >= 0);
      if (r < 0) r = r + m;
      t  = sx - sy - c;
    end
    ov = (t >= h) || (t < -h);
    if (SAT_EN && ov) r = (t > 0) ? h - 1 : h;
    return {ov, co, r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_check32(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                              input logic ts, input logic [31:0] er, input logic eco,
                              input logic eov, input string tag);
    int lat;
    @(negedge clk);
    a32 = ta; b32 = tb; ci32 = tci; s32 = ts; in_valid32 = 1'b1; out_ready32 = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready32), 64'd1);
    @(negedge clk);
    in_valid32 = 1'b0;
    #1 lat = 1;
    while (!out_valid32 && lat < 10) begin
      @(negedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_result"}, 64'(res32), 64'(er));
    chk({tag, "_cout"}, 64'(co32), 64'(eco));
    chk({tag, "_overflow"}, 64'(ovf32), 64'(eov));
`ifdef ADD_SUB_SAT_EN
    chk({tag, "_sat"}, 64'(sat32), 64'(eov));
`endif
    @(negedge clk);
    #1 chk({tag, "_single"}, 64'(out_valid32), 64'd0);
  endtask

  initial begin
    int sent, got, last_cyc, stale, sent16, got16, sent8, got8;
    logic [33:0] held, e;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready32), 64'd0);
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_outputs", 64'({ovf32, co32, res32}), 64'd0);
`ifdef ADD_SUB_SAT_EN
    chk("rst_sat", 64'(sat32), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready32), 64'd1);

    // Directed arithmetic with exact latency
    send_check32(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0,
                 SAT_EN ? 32'h7FFFFFFF : 32'hFFFFFFFE, 1'b0, 1'b1, "add_ovf");
    send_check32(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, "sub_borrow");
    send_check32(32'h80000000, 32'h00000001, 1'b0, 1'b1,
                 SAT_EN ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");
    send_check32(32'h0F0A000A, 32'h000D00FF, 1'b1, 1'b0, 32'h0F17010A, 1'b0, 1'b0, "add_cin");
    send_check32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
                 SAT_EN ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, "add_ovf1");
    send_check32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap");
    send_check32(32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, "sub_bin");
    send_check32(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1,
                 SAT_EN ? 32'h80000000 : 32'h00000001, 1'b1, 1'b1, "sub_neg_ovf");
    send_check32(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, "carry_ripple");

    // Backpressure: 8 back-to-back beats, consumer stalls cycles 5..7
    sent = 0; got = 0; last_cyc = -1; held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      in_valid32  = (sent < 8);
      a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); s32 = 1'($urandom);
      out_ready32 = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
      if (c == 5) held = {ovf32, co32, res32};
      if (c >= 6 && c <= 7) begin
        chk("bp_hold_valid", 64'(out_valid32), 64'd1);
        chk("bp_hold_data", 64'({ovf32, co32, res32}), 64'(held));
      end
      if (out_valid32 && out_ready32) begin
        chk("bp_nonempty", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk("bp_data", 64'({ovf32, co32, res32}), 64'(e));
        end
        got++;
        if (got == 8) last_cyc = c;
      end
      if (in_valid32 && in_ready32) begin
        q32.push_back(model(32, a32, b32, ci32, s32));
        sent++;
      end
    end
    // 4-cycle latency, 8 beats at one per cycle, 3 stalled cycles; first beat at cycle 0.
    chk("bp_last_cycle", 64'(last_cyc), 64'(4 + 8 + 3 - 1));
    chk("bp_drained", 64'(q32.size()), 64'd0);
    in_valid32 = 1'b0; out_ready32 = 1'b1;

    // Reset with three beats in flight, the oldest stalled at the output
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid32 = 1'b1; a32 = $urandom; b32 = $urandom | 32'h1; out_ready32 = 1'b0;
    end
    @(negedge clk);
    in_valid32 = 1'b0;
    @(negedge clk);
    #1 chk("mid_pre_valid", 64'(out_valid32), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid32), 64'd0);
    chk("mid_outputs", 64'({ovf32, co32, res32}), 64'd0);
    chk("mid_in_ready", 64'(in_ready32), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready32 = 1'b1;
    #1 chk("mid_release_ready", 64'(in_ready32), 64'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (out_valid32) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);
    send_check32(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, "post_rst");

    // Random sweep of 16/4 and 8/8 with random valid and ready
    sent16 = 0; got16 = 0; sent8 = 0; got8 = 0;
    for (int cyc = 0; cyc < 20000 && (got16 < N_SWEEP || got8 < N_SWEEP); cyc++) begin
      @(negedge clk);
      in_valid16  = (sent16 < N_SWEEP) && ($urandom_range(3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); s16 = 1'($urandom);
      out_ready16 = ($urandom_range(3) != 0);
      in_valid8   = (sent8 < N_SWEEP) && ($urandom_range(3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); s8 = 1'($urandom);
      out_ready8  = ($urandom_range(3) != 0);
      #1;
      if (out_valid16 && out_ready16) begin
        chk("sw16_nonempty", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          chk("sw16_data", 64'({ovf16, co16, 16'h0, res16}), 64'(e));
        end
        got16++;
      end
      if (in_valid16 && in_ready16) begin
        q16.push_back(model(16, a16, b16, ci16, s16));
        sent16++;
      end
      if (out_valid8 && out_ready8) begin
        chk("sw8_nonempty", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("sw8_data", 64'({ovf8, co8, 24'h0, res8}), 64'(e));
        end
        got8++;
      end
      if (in_valid8 && in_ready8) begin
        q8.push_back(model(8, a8, b8, ci8, s8));
        sent8++;
      end
    end
    chk("sw16_count", 64'(got16), 64'(N_SWEEP));
    chk("sw8_count", 64'(got8), 64'(N_SWEEP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
